// File: rtl/elevador_pkg.sv
// Shared types and floor helpers for the three-floor elevator controller.
package elevador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  localparam logic [1:0] PISO_0   = 2'd0;
  localparam logic [1:0] PISO_1   = 2'd1;
  localparam logic [1:0] PISO_2   = 2'd2;
  localparam logic [1:0] PISO_MAX = PISO_2;

  function automatic logic req_above(input logic [2:0] req, input logic [1:0] piso);
    case (piso)
      PISO_0:  return req[1] | req[2];
      PISO_1:  return req[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic req_below(input logic [2:0] req, input logic [1:0] piso);
    case (piso)
      PISO_1:  return req[0];
      PISO_2:  return req[0] | req[1];
      default: return 1'b0;
    endcase
  endfunction

  // One-hot floor mask; an out-of-range floor yields an empty mask.
  function automatic logic [2:0] piso_oh(input logic [1:0] piso);
    return 3'b001 << piso;
  endfunction

endpackage

// File: rtl/elevador_sinc_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector; one pulse per input rise.
module sinc_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s3, s2, s1} <= 3'b000;
    end else begin
      {s3, s2, s1} <= {s2, s1, in};
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/elevador_ctrl.sv
// Floor-sequencing controller: latches calls, picks direction, drives motor and door.
// state   | meaning
// IDLE    | parked with door closed, choosing next action every clk
// UP/DOWN | travelling one floor per TRAVEL_TICKS ticks
// DOOR    | door open for DOOR_TICKS ticks after last in-floor press
module elevador_ctrl
  import elevador_pkg::*;
#(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic [2:0] btn,
  output logic [1:0] piso,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [2:0] req_pending
);

  localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t          state, state_nxt;
  logic [1:0]      piso_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      req, req_nxt;
  logic            last_up, last_up_nxt;
  logic            tick_p;
  logic [2:0]      oh, oh_up, oh_dn;

  sinc_flanco u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (tick_in),
    .pulse (tick_p)
  );

  always_comb begin
    state_nxt   = state;
    piso_nxt    = piso;
    cnt_nxt     = cnt;
    last_up_nxt = last_up;
    oh          = piso_oh(piso);
    oh_up       = piso_oh(piso + 2'd1);
    oh_dn       = piso_oh(piso - 2'd1);
    // An in-floor press during DOOR restarts the dwell instead of latching a call.
    req_nxt     = req | (btn & ~((state == ST_DOOR) ? oh : 3'b000));

    if (piso > PISO_MAX) begin
      state_nxt = ST_IDLE;
      piso_nxt  = PISO_0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (|(req & oh)) begin
            state_nxt = ST_DOOR;
            req_nxt   = req_nxt & ~oh;
          end else if (req_above(req, piso) && req_below(req, piso)) begin
            state_nxt = last_up ? ST_UP : ST_DOWN;
          end else if (req_above(req, piso)) begin
            state_nxt   = ST_UP;
            last_up_nxt = 1'b1;
          end else if (req_below(req, piso)) begin
            state_nxt   = ST_DOWN;
            last_up_nxt = 1'b0;
          end
        end
        ST_UP: begin
          if (piso == PISO_MAX) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (tick_p) begin
            if (cnt == CW'(TRAVEL_TICKS - 1)) begin
              piso_nxt = piso + 2'd1;
              cnt_nxt  = '0;
              if (|(req & oh_up)) begin
                state_nxt = ST_DOOR;
                req_nxt   = req_nxt & ~oh_up;
              end else if (!req_above(req, piso_nxt)) begin
                state_nxt = ST_IDLE;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        ST_DOWN: begin
          if (piso == PISO_0) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (tick_p) begin
            if (cnt == CW'(TRAVEL_TICKS - 1)) begin
              piso_nxt = piso - 2'd1;
              cnt_nxt  = '0;
              if (|(req & oh_dn)) begin
                state_nxt = ST_DOOR;
                req_nxt   = req_nxt & ~oh_dn;
              end else if (!req_below(req, piso_nxt)) begin
                state_nxt = ST_IDLE;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        ST_DOOR: begin
          if (|(btn & oh)) begin
            cnt_nxt = '0;
          end else if (tick_p) begin
            if (cnt == CW'(DOOR_TICKS - 1)) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      piso       <= PISO_0;
      cnt        <= '0;
      req        <= 3'b000;
      last_up    <= 1'b1;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
    end else begin
      state      <= state_nxt;
      piso       <= piso_nxt;
      cnt        <= cnt_nxt;
      req        <= req_nxt;
      last_up    <= last_up_nxt;
      motor_up   <= (state_nxt == ST_UP);
      motor_down <= (state_nxt == ST_DOWN);
      door_open  <= (state_nxt == ST_DOOR);
    end
  end

  assign req_pending = req;

endmodule

// File: doc/elevador_ctrl.md
# elevador_ctrl

- **Function:** floor-sequencing controller for the three-floor elevator.
- **Position:** directly downstream of the frequency divider; it consumes the divider's slow square-wave output as a timing tick.
- **Behaviour:** latches hall calls, decides travel direction, drives the motor and door outputs, and tracks the current floor.
- **Clocking:** all logic runs on the fast system clock; the divided clock is used only as a sampled enable, never as a clock.

## Interface
Parameters:
- TRAVEL_TICKS, 4, tick edges needed to move one floor (≥1)
- DOOR_TICKS, 3, tick edges the door stays open (≥1)

Ports:
- clk  in  1  system clock, same clock that feeds the divider
- rst_n  in  1  one clock; reset is asynchronous and active-low
- tick_in  in  1  divider output (clk2); asynchronous to this block's logic, sampled here
- btn  in  3  call buttons, bit i = floor i, level, synchronous to clk
- piso  out  2  current floor, 0..2
- motor_up  out  1  motor drive upward
- motor_down  out  1  motor drive downward
- door_open  out  1  door open
- req_pending  out  3  latched requests, bit i = floor i

## Operation
- **Tick detection**
  - tick_in passes through a 2-FF synchronizer, then a one-FF delay.
  - tick_p = sync2 & ~sync3: a single-cycle pulse per tick_in rising edge.
  - All counters advance only on tick_p.
- **Request latch**
  - req[i] is set when btn[i]=1.
  - Exception: btn[i] for the current floor while in DOOR does not set req[i]; it restarts the door count instead.
  - req[i] is cleared on entry to DOOR at floor i.
  - If set and clear happen on the same edge, clear wins.
- **States:** IDLE, MOVE_UP, MOVE_DOWN, DOOR. Outputs are Moore-decoded and registered.
- **IDLE** (evaluated every clk):
  - req[piso] set → DOOR.
  - Otherwise, a request exists both above and below → keep last_dir (reset value = up).
  - Otherwise, only above → MOVE_UP; only below → MOVE_DOWN.
  - Otherwise → stay in IDLE.
- **MOVE_UP / MOVE_DOWN:**
  - cnt increments on tick_p.
  - On tick_p with cnt == TRAVEL_TICKS-1: piso ±1, cnt ← 0.
  - Next state from the new floor: req[new] set → DOOR; otherwise a request further in the same direction → remain moving; otherwise → IDLE.
- **DOOR:**
  - cnt increments on tick_p.
  - On tick_p with cnt == DOOR_TICKS-1 → IDLE, cnt ← 0.
  - btn[piso]=1 → cnt ← 0, door stays open.
- **Outputs:** motor_up=1 only in MOVE_UP; motor_down=1 only in MOVE_DOWN; door_open=1 only in DOOR. The motor outputs are never both 1.
- **Saturation:** MOVE_UP never starts at floor 2 and MOVE_DOWN never at floor 0. If an illegal floor value (3) is ever seen, force piso ← 0 and go to IDLE.
- **Reset:** state=IDLE, piso=0, cnt=0, req=000, last_dir=up, synchronizer FFs=0, all outputs 0. Reset asserted mid-travel aborts immediately, with no floor completion.

## Timing
- tick_in rising edge → tick_p high on the 2nd or 3rd clk edge after it, for exactly one cycle.
- tick_in high for many cycles still yields a single pulse.
- Button → req_pending visible: 1 clk.
- IDLE decision → motor/door output asserted: 1 clk after req is latched.
- Floor change and the following state change occur on the same clk edge as the terminal tick_p.
- One-floor travel: exactly TRAVEL_TICKS tick edges.
- Door dwell: exactly DOOR_TICKS tick edges after the last in-floor button press.
- A request arriving during MOVE is considered at the next floor arrival, not mid-floor.

## Structure
- **Shared defines header, elevador_pkg.vh:**
  - state encodings ST_IDLE, ST_UP, ST_DOWN, ST_DOOR (2 bits)
  - floor constants PISO_0..PISO_2
  - PISO_MAX=2
- **Sub-module sinc_flanco** (synchronizer + rising-edge detector)
  - Ports: clk, rst_n, in, pulse.
  - Reusable for future button inputs.
- **Counter:** a single shared cnt, width clog2(max(TRAVEL_TICKS, DOOR_TICKS)).

## Test plan
Bench setup: TRAVEL_TICKS=4, DOOR_TICKS=3, tick_in period 20 clk. Every scenario also asserts that motor_up & motor_down is never 1.
- **Reset:** drive rst_n=0 mid-simulation → piso=0, all outputs 0, req_pending=000 asynchronously.
- **Single call:** btn=100 for 1 clk from floor 0 → motor_up for 8 tick edges, piso 0→1→2, then door_open for 3 ticks, req_pending=000, then IDLE.
- **Call at current floor:** btn=001 at floor 0 → door_open the next clk, 3 ticks; btn[0] pulses during the open interval extend it to 3 ticks after the last press.
- **Both directions pending:** at floor 1 after going up, btn=101 → serves floor 2 first (last_dir=up), then descends to floor 0.
- **Intermediate stop:** traveling 0→2 with btn[1] pressed before arrival at floor 1 → stops at floor 1, door 3 ticks, then continues up.
- **Long tick_in high:** hold tick_in=1 for 100 clk → exactly one tick_p, cnt advances by 1.
